// File: rtl/ps2_move_if.sv
// Bundle of the PS/2 pins and the decoded byte/move outputs of ps2_move_decoder.
// The slave modport is the decoder, and the master modport is the keyboard or pin driver side.
interface ps2_move_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] move;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  move, byte_valid, byte_data, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output move, byte_valid, byte_data, frame_err
    );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard frame receiver with E0/F0 prefix decoding and typematic-repeat suppression.
// Emits one-cycle game move codes on bus.move.
module ps2_move_decoder #(
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst,
    ps2_move_if.slave   bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    function automatic logic [2:0] map_key(input logic [7:0] b, input logic ext);
        case ({ext, b})
            9'h01D:  return 3'd1;
            9'h01B:  return 3'd2;
            9'h01C:  return 3'd3;
            9'h023:  return 3'd4;
            9'h05A:  return 3'd5;
            9'h02D:  return 3'd6;
            9'h175:  return 3'd1;
            9'h172:  return 3'd2;
            9'h16B:  return 3'd3;
            9'h174:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    logic          kclk_s1_q, kclk_s2_q, kclk_prev_q, kdat_s1_q, kdat_s2_q;
    logic          edge_s;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic [2:0]    move_q, move_d, held_q, held_d, code_s;
    logic          brk_q, brk_d, ext_q, ext_d;

    // Two-flop synchronizers; lines reset high (PS/2 idle) so reset release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_s1_q   <= 1'b1;
            kclk_s2_q   <= 1'b1;
            kclk_prev_q <= 1'b1;
            kdat_s1_q   <= 1'b1;
            kdat_s2_q   <= 1'b1;
        end else begin
            kclk_s1_q   <= bus.ps2_clk;
            kclk_s2_q   <= kclk_s1_q;
            kclk_prev_q <= kclk_s2_q;
            kdat_s1_q   <= bus.ps2_data;
            kdat_s2_q   <= kdat_s1_q;
        end
    end

    assign edge_s = kclk_prev_q & ~kclk_s2_q;

    // Frame FSM: start/data/parity/stop with an inter-edge timeout.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        byte_data_d  = byte_data_q;
        if (state_q == S_IDLE || edge_s) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (edge_s && !kdat_s2_q) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (edge_s) begin
                    shift_d = {kdat_s2_q, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (edge_s) begin
                    par_d   = kdat_s2_q;
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (edge_s) begin
                    state_d = S_IDLE;
                    if (kdat_s2_q && odd_parity_ok(shift_q, par_q)) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !edge_s && tmo_q == TW'(TIMEOUT_CYC)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end else begin
            tmo_d = tmo_d;
        end
    end

    // Frame FSM and byte output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            byte_data_q  <= byte_data_d;
        end
    end

    assign code_s = map_key(byte_data_q, ext_q);

    // Prefix tracking and held-key repeat suppression; acts one cycle after byte_valid.
    always_comb begin
        move_d = 3'd0;
        held_d = held_q;
        brk_d  = brk_q;
        ext_d  = ext_q;
        if (frame_err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (byte_valid_q) begin
            if (byte_data_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (byte_data_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (brk_q) begin
                    if (code_s == held_q) begin
                        held_d = 3'd0;
                    end else begin
                        held_d = held_q;
                    end
                end else if (code_s != 3'd0 && code_s != held_q) begin
                    move_d = code_s;
                    held_d = code_s;
                end else begin
                    held_d = held_q;
                end
            end
        end else begin
            move_d = 3'd0;
        end
    end

    // Decoder state and move output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_q <= 3'd0;
            held_q <= 3'd0;
            brk_q  <= 1'b0;
            ext_q  <= 1'b0;
        end else begin
            move_q <= move_d;
            held_q <= held_d;
            brk_q  <= brk_d;
            ext_q  <= ext_d;
        end
    end

    assign bus.move       = move_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder: directed vector table, timeout/reset sequences,
// then random key streams checked against a lookup-table reference model.
module tb_ps2_move_decoder;
    localparam int TMO = 200;
    localparam int HP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_move_if bus ();

    ps2_move_decoder #(.TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         badp;
        bit         badst;
        int         ev;
        int         ee;
        int         em;
    } vec_t;

    vec_t       tbl[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         mv_cnt = 0, bv_cnt = 0, fe_cnt = 0;
    int         frame_mv = 0;
    bit         prev_bv = 1'b0, prev_mv = 1'b0;
    logic [7:0] exp_bd = 8'h00;
    int         norm_map[bit [7:0]];
    int         ext_map[bit [7:0]];
    int         m_held = 0;
    bit         m_brk = 1'b0, m_ext = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: counts pulses and checks the move-after-valid and single-cycle rules.
    always @(negedge clk) begin
        if (bus.move != 3'd0) begin
            mv_cnt++;
            frame_mv = int'(bus.move);
            chk("move_follows_valid", int'(prev_bv), 1);
            chk("move_one_cycle", int'(prev_mv), 0);
        end
        if (bus.byte_valid) bv_cnt++;
        if (bus.frame_err) fe_cnt++;
        prev_bv = bus.byte_valid;
        prev_mv = (bus.move != 3'd0);
    end

    task automatic send_bit(input bit v);
        bus.ps2_data = v;
        wait_clk(HP);
        bus.ps2_clk = 1'b0;
        wait_clk(HP);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badp, input bit badst);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ badp);
        send_bit(~badst);
        bus.ps2_data = 1'b1;
        wait_clk(12);
    endtask

    task automatic run_check(input string tag, input logic [7:0] b, input bit badp, input bit badst,
                             input int ev, input int ee, input int em);
        int bv0, fe0, mv0;
        bv0 = bv_cnt; fe0 = fe_cnt; mv0 = mv_cnt; frame_mv = 0;
        send_frame(b, badp, badst);
        if (ev != 0) exp_bd = b;
        chk({tag, "_valid"}, bv_cnt - bv0, ev);
        chk({tag, "_err"}, fe_cnt - fe0, ee);
        chk({tag, "_move_cnt"}, mv_cnt - mv0, (em != 0) ? 1 : 0);
        chk({tag, "_move"}, frame_mv, em);
        chk({tag, "_byte_data"}, int'(bus.byte_data), int'(exp_bd));
    endtask

    function automatic int model_good(input logic [7:0] b);
        int  c;
        bit  was_brk;
        if (b == 8'hF0) begin m_brk = 1'b1; return 0; end
        if (b == 8'hE0) begin m_ext = 1'b1; return 0; end
        if (m_ext) c = ext_map.exists(b) ? ext_map[b] : 0;
        else       c = norm_map.exists(b) ? norm_map[b] : 0;
        was_brk = m_brk;
        m_brk = 1'b0;
        m_ext = 1'b0;
        if (was_brk) begin
            if (c == m_held) m_held = 0;
            return 0;
        end
        if (c != 0 && c != m_held) begin
            m_held = c;
            return c;
        end
        return 0;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_move"}, int'(bus.move), 0);
        chk({tag, "_byte_valid"}, int'(bus.byte_valid), 0);
        chk({tag, "_byte_data"}, int'(bus.byte_data), 0);
        chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
    endtask

    initial begin
        logic [7:0] pool [14];
        int bv0, fe0, mv0;

        norm_map[8'h1D] = 1; norm_map[8'h1B] = 2; norm_map[8'h1C] = 3;
        norm_map[8'h23] = 4; norm_map[8'h5A] = 5; norm_map[8'h2D] = 6;
        ext_map[8'h75] = 1; ext_map[8'h72] = 2; ext_map[8'h6B] = 3; ext_map[8'h74] = 4;
        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h2D, 8'h75,
                 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hE0};

        tbl.push_back('{8'h1D, 1'b0, 1'b0, 1, 0, 1});
        tbl.push_back('{8'h1D, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h1D, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h1D, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h1D, 1'b0, 1'b0, 1, 0, 1});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h1D, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h75, 1'b0, 1'b0, 1, 0, 1});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h75, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h75, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h6B, 1'b0, 1'b0, 1, 0, 3});
        tbl.push_back('{8'h23, 1'b1, 1'b0, 0, 1, 0});
        tbl.push_back('{8'h23, 1'b0, 1'b0, 1, 0, 4});
        tbl.push_back('{8'h2D, 1'b0, 1'b1, 0, 1, 0});
        tbl.push_back('{8'h2D, 1'b0, 1'b0, 1, 0, 6});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 1, 0, 0});
        tbl.push_back('{8'h2D, 1'b0, 1'b0, 1, 0, 0});

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_clk(5);
        chk_outputs_zero("reset");
        rst = 1'b0;
        wait_clk(5);

        foreach (tbl[i])
            run_check($sformatf("vec%0d", i), tbl[i].b, tbl[i].badp, tbl[i].badst,
                      tbl[i].ev, tbl[i].ee, tbl[i].em);

        // Timeout: start bit plus four data bits, then silence.
        bv0 = bv_cnt; fe0 = fe_cnt; mv0 = mv_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        bus.ps2_data = 1'b1;
        wait_clk(TMO + 5);
        chk("tmo_err", fe_cnt - fe0, 1);
        chk("tmo_valid", bv_cnt - bv0, 0);
        chk("tmo_move", mv_cnt - mv0, 0);
        run_check("after_tmo", 8'h5A, 1'b0, 1'b0, 1, 0, 5);

        // Reset mid-frame after an E0 prefix.
        run_check("pre_rst_e0", 8'hE0, 1'b0, 1'b0, 1, 0, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        bus.ps2_data = 1'b1;
        fe0 = fe_cnt;
        #3 rst = 1'b1;
        #1 chk_outputs_zero("async_rst");
        wait_clk(4);
        rst = 1'b0;
        exp_bd = 8'h00;
        wait_clk(4);
        chk("rst_no_err", fe_cnt - fe0, 0);
        run_check("post_rst_75", 8'h75, 1'b0, 1'b0, 1, 0, 0);

        // Random key streams against the reference model; state is clean after reset.
        m_held = 0; m_brk = 1'b0; m_ext = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            bit bad;
            int em;
            b   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
            bad = ($urandom_range(0, 9) == 0);
            if (bad) begin
                m_brk = 1'b0;
                m_ext = 1'b0;
                run_check($sformatf("rnd%0d_bad", n), b, 1'b1, 1'b0, 0, 1, 0);
            end else begin
                em = model_good(b);
                run_check($sformatf("rnd%0d_%02h", n, b), b, 1'b0, 1'b0, 1, 0, em);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_move_decoder.md
# ps2_move_decoder

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and converts them into one-cycle game move commands on `move[2:0]`. It sits directly upstream of the game logic block, which samples `move` on `clk`. The block handles frame reception, parity and stop checking, and timeout recovery. It also decodes E0 (extended) and F0 (break) prefixes and suppresses typematic auto-repeat.

## Interface
- `TIMEOUT_CYC`, default 200000: `clk` cycles without a PS/2 falling edge mid-frame before the frame is aborted (2 ms at 100 MHz).
- `clk`: input, 1 bit, 100 MHz system clock.
- `rst`: input, 1 bit. Reset is asynchronous and active-high.
- `ps2_clk`: input, 1 bit, raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`: input, 1 bit, raw PS/2 data, asynchronous to `clk`.
- `move`: output, 3 bits, one-cycle command pulse; 0 when idle.
- `byte_valid`: output, 1 bit, one-cycle pulse when a good byte is received.
- `byte_data`: output, 8 bits, last good byte; holds its value between pulses.
- `frame_err`: output, 1 bit, one-cycle pulse on a parity, stop or timeout error.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A falling edge is the sync'd clock going 1→0, and the sync'd data is sampled in that same cycle (call it edge cycle E).
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: an edge with data 0 goes to DATA with bit count = 0. An edge with data 1 is ignored.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: if data = 1 and odd parity holds over data plus parity, the byte is good. Otherwise raise `frame_err`. Either way, return to IDLE.
  - Timeout: in DATA, PARITY or STOP, if a counter reaches `TIMEOUT_CYC` with no edge, raise `frame_err` and go to IDLE. The counter is cleared on every edge.
- **Byte decoder** (acts on good bytes only):
  - 0xF0 sets `brk`. 0xE0 sets `ext`. Neither produces a move.
  - Any other byte is looked up with the current `ext`, then `brk` and `ext` are both cleared.
  - Any `frame_err` also clears `brk` and `ext`.
- **Move map:**

  | Command | Move code | Normal keys | Extended keys (E0 prefix) |
  |---|---|---|---|
  | up | 1 | W (0x1D) | 0x75 |
  | down | 2 | S (0x1B) | 0x72 |
  | left | 3 | A (0x1C) | 0x6B |
  | right | 4 | D (0x23) | 0x74 |
  | confirm/start | 5 | Enter (0x5A) | — |
  | restart | 6 | R (0x2D) | — |

  - Code 7 is never generated. Every other byte maps to 0, meaning no action.
  - Non-extended 0x75/0x72/0x6B/0x74 (keypad keys) map to 0.
- **Repeat suppression:** a 3-bit `held` register tracks the currently held key.
  - Make of mapped code c ≠ 0 with c ≠ `held`: pulse `move` = c and set `held` = c.
  - Make with c == `held`: no pulse. This covers typematic repeat.
  - Break with c == `held`: clear `held`. Break of any other key: no effect.
  - A break never pulses `move`.

## Timing
- **Reset values:** `move` = 0, `byte_valid` = 0, `byte_data` = 0x00, `frame_err` = 0. FSM in IDLE; bit count, timeout counter, `brk`, `ext` and `held` all cleared.
- Reset asserted mid-frame drops the partial frame immediately. No error pulse is generated.
- **Sync latency:** 2 `clk` cycles from a pin edge to edge cycle E.
- Let E11 be the stop-bit edge cycle. `byte_valid`, `byte_data` and `frame_err` update at E11+1.
- `move` pulses at E11+2, for exactly 1 cycle.
- A timeout error pulses `frame_err` in the cycle after the counter reaches `TIMEOUT_CYC`.
- All outputs are registered.
- A new start bit is accepted in the cycle after STOP returns to IDLE, so back-to-back frames are handled.

## Test plan
- Frame 0x1D, good parity, stop = 1 → `byte_valid` at E11+1 with `byte_data` = 0x1D; `move` = 1 for one cycle at E11+2.
- Sequence 1D, 1D, 1D (typematic), then F0 1D, then 1D → `move` = 1 exactly twice: on the first 1D and on the final 1D. No `move` on any F0 or break byte.
- E0 75, then F0-free 75 alone → first gives `move` = 1; the lone 75 gives no `move` because it is non-extended. E0 6B gives `move` = 3.
- Frame 0x23 with a flipped parity bit → `frame_err` pulse; `byte_valid` stays 0, `move` stays 0, `byte_data` unchanged. The next good 0x23 frame gives `move` = 4.
- Send start bit plus 4 data bits, then hold `ps2_clk` high for `TIMEOUT_CYC`+5 cycles → single `frame_err` pulse; FSM is back in IDLE. A following good 0x5A frame gives `move` = 5.
- Assert `rst` mid-frame after sending E0 → all outputs return to 0 asynchronously. A following lone 0x75 gives no `move`, confirming `ext` was cleared.
